// File: rtl/if_fetch_if.sv
// Instruction SRAM request/response bus between the fetch stage (master) and the SRAM (slave).
interface if_fetch_if;
   logic        req;
   logic [31:0] addr;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (output req, addr, input addr_ok, data_ok, rdata);
   modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: owns the fetch PC, runs the SRAM handshake,
// buffers the returned word and honours the branch delay slot.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STALL_W-1:0] stall,
   input  logic [32:0]        br_bus,
   if_fetch_if.master         inst_sram,
   output logic [32:0]        if_to_id_bus,
   output logic [31:0]        if_inst,
   output logic               stallreq
);
   typedef enum logic [1:0] {REQ, WAIT, DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] pc_f, inst_buf, redir_addr, next_pc, req_addr;
   logic        redir_valid, advance, req_raw;
   logic        br_e;
   logic [31:0] br_addr;
   logic        unused_stall;

   assign br_e         = br_bus[32];
   assign br_addr      = br_bus[31:0];
   assign unused_stall = ^stall;
   assign advance      = (state == DONE) & ~stall[0];
   // A branch seen this cycle beats one latched while the fetch was busy.
   assign next_pc      = br_e ? br_addr : redir_valid ? redir_addr : pc_f + 32'd4;

   always_comb begin
      state_nx = state;
      req_raw  = 1'b0;
      req_addr = pc_f;
      case (state)
         REQ: begin
            req_raw = 1'b1;
            if (inst_sram.addr_ok) state_nx = WAIT;
         end
         WAIT: begin
            if (inst_sram.data_ok) state_nx = DONE;
         end
         DONE: begin
            if (advance) begin
               req_raw  = 1'b1;
               req_addr = next_pc;
               state_nx = inst_sram.addr_ok ? WAIT : REQ;
            end
         end
         default: state_nx = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= REQ;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_f     <= RESET_PC;
         inst_buf <= 32'b0;
      end else begin
         if (advance) pc_f <= next_pc;
         if (state == WAIT && inst_sram.data_ok) inst_buf <= inst_sram.rdata;
      end
   end

   // The in-flight or held fetch is the delay slot; the redirect waits for the next advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redir_valid <= 1'b0;
         redir_addr  <= 32'b0;
      end else if (advance) begin
         redir_valid <= 1'b0;
      end else if (br_e) begin
         redir_valid <= 1'b1;
         redir_addr  <= br_addr;
      end
   end

   assign inst_sram.req  = req_raw & rst_n;
   assign inst_sram.addr = req_addr;
   assign if_to_id_bus   = (state == DONE) ? {1'b1, pc_f} : 33'b0;
   assign if_inst        = (state == DONE) ? inst_buf : 32'b0;
   assign stallreq       = (state != DONE);
endmodule
